// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into instruction memory, then releases the core reset.
// Optional trailing XOR checksum stage is compiled in when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_reset_n
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERR
    } state_t;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t            state;
    state_t            next_state;
    logic [15:0]       len;
    logic [ADDR_W-1:0] counter;
    logic              xfer;
    logic [15:0]       len_now;
    logic              len_bad;
    logic              last_byte;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign xfer      = byte_valid & byte_ready;
    assign len_now   = {len[15:8], byte_data};
    assign len_bad   = ({1'b0, len_now} > DEPTH_W) || (len_now[1:0] != 2'b00);
    // Compare in 17 bits so LEN == DEPTH ends the load before the counter wraps.
    assign last_byte = ({{(17-ADDR_W){1'b0}}, counter} + 17'd1) == {1'b0, len};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) next_state = LEN_HI;
            end
            LEN_HI: begin
                if (xfer) next_state = LEN_LO;
            end
            LEN_LO: begin
                if (xfer) begin
                    if (len_now == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        next_state = CSUM;
`else
                        next_state = DONE;
`endif
                    end else if (len_bad) begin
                        next_state = ERR;
                    end else begin
                        next_state = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer && last_byte) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    next_state = CSUM;
`else
                    next_state = DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (xfer) next_state = (byte_data == csum) ? DONE : ERR;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        byte_ready  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        cpu_reset_n = 1'b0;
        case (state)
            LEN_HI, LEN_LO, DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
`endif
            DONE: begin
                done        = 1'b1;
                cpu_reset_n = 1'b1;
            end
            ERR: begin
                err = 1'b1;
            end
            default: ;
        endcase
    end

    // Write port is registered: the strobe appears the cycle after the byte is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len       <= 16'd0;
            counter   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum      <= 8'd0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        counter <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum    <= 8'd0;
`endif
                    end
                end
                LEN_HI: begin
                    if (xfer) len[15:8] <= byte_data;
                end
                LEN_LO: begin
                    if (xfer) len[7:0] <= byte_data;
                end
                DATA: begin
                    if (xfer) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= counter;
                        mem_wdata <= byte_data;
                        counter   <= counter + ADDR_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum      <= csum ^ byte_data;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning instruction memory size in bytes.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning byte address width, with DEPTH = 2^ADDR_W.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
REQ-006 SHALL have port byte_valid, input, 1 bit: the source presents byte_data.
REQ-007 SHALL have port byte_data, input, 8 bits: the incoming stream byte.
REQ-008 SHALL have port byte_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-009 SHALL have port mem_we, output, 1 bit: single-cycle byte write strobe to instruction memory.
REQ-010 SHALL have port mem_addr, output, ADDR_W bits: byte address of the write.
REQ-011 SHALL have port mem_wdata, output, 8 bits: byte to write.
REQ-012 SHALL have port busy, output, 1 bit: high in LEN_HI, LEN_LO, DATA (and CSUM).
REQ-013 SHALL have port done, output, 1 bit: high while in DONE.
REQ-014 SHALL have port err, output, 1 bit: high while in ERR.
REQ-015 SHALL have port cpu_reset_n, output, 1 bit: active-low core reset, asserted (0) unless the state is DONE.

Function
REQ-016 SHALL complete a transfer in the cycle where byte_valid and byte_ready are both high; no other byte is consumed.
REQ-017 SHALL drive byte_ready high exactly in LEN_HI, LEN_LO, DATA and CSUM.
REQ-018 SHALL implement states IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE and ERR.
REQ-019 SHALL go from IDLE, DONE or ERR to LEN_HI on start, clearing the address counter to 0.
REQ-020 SHALL capture LEN[15:8] on a transfer in LEN_HI and move to LEN_LO.
REQ-021 SHALL capture LEN[7:0] on a transfer in LEN_LO.
REQ-022 SHALL, in LEN_LO, branch on LEN: 0 goes to DONE (or CSUM per REQ-033); LEN > DEPTH or LEN[1:0] != 0 goes to ERR; otherwise go to DATA.
REQ-023 SHALL, on each DATA transfer, register mem_we=1, mem_addr=counter and mem_wdata=byte_data, visible the next cycle (latency 1), then increment the counter.
REQ-024 SHALL store stream bytes in address order, with the first byte of each word at the lowest address (big-endian instruction byte order).
REQ-025 SHALL leave DATA after the transfer where counter+1 == LEN; LEN == DEPTH terminates without counter wrap being observable.
REQ-026 SHALL hold mem_we low in every cycle other than the cycle after a DATA transfer.
REQ-027 SHALL ignore start while busy is high.
REQ-028 SHALL release cpu_reset_n to 1 in the first cycle of DONE, and de-assert it again on a restart via start.
REQ-029 SHALL treat byte_valid as don't-care in IDLE, DONE and ERR.

Reset
REQ-030 SHALL, while reset=0, asynchronously force: state IDLE; counter and LEN 0; mem_we 0; mem_addr 0; mem_wdata 0; byte_ready 0; busy 0; done 0; err 0; cpu_reset_n 0.
REQ-031 SHALL, if reset is asserted mid-load, abandon the load with no further writes; memory contents already written are undefined to the core.

Configuration
REQ-032 SHALL compile the CSUM state and checksum logic only when the macro IMEM_LOADER_CHECKSUM_EN is defined.
REQ-033 SHALL, with IMEM_LOADER_CHECKSUM_EN defined, keep a running XOR of the payload bytes (cleared on start), expect one trailing byte in CSUM, go to DONE if it matches and to ERR otherwise; LEN=0 also goes through CSUM and expects 0x00.
REQ-034 SHALL, with IMEM_LOADER_CHECKSUM_EN undefined, go from DATA (or from LEN_LO when LEN=0) directly to DONE, with CSUM unreachable and absent.

Verification
REQ-035 Bench SHALL drive reset low then high, followed by start and stream 00 04 00 40 80 93 -> writes 0x00/0x40/0x80/0x93 to addresses 0..3, then done=1 and cpu_reset_n=1.
REQ-036 Bench SHALL stream length 00 06 -> err=1, no mem_we pulse, and cpu_reset_n stays 0.
REQ-037 Bench SHALL stream length 01 00 plus 256 bytes with byte_valid toggled randomly -> exactly 256 writes to addresses 0..255, then DONE.
REQ-038 Bench SHALL stream length 00 08, 3 data bytes, then drive reset low -> all outputs match their reset values immediately, and there are no further writes.
REQ-039 Bench SHALL, with IMEM_LOADER_CHECKSUM_EN defined, stream 00 04 00 40 80 93 then checksum 0x53 -> DONE; the same stream with checksum 0x52 -> ERR.
REQ-040 Bench SHALL pulse start during DATA -> the pulse is ignored and the load completes normally.
